tile_sequencer: RTL and testbench

TILE_SEQUENCER -- requirements
Module: tile_sequencer

---
 rtl/acc_pkg.sv | 23 ++
 rtl/stall_addr_counter.sv | 30 +++
 rtl/tile_sequencer.sv | 153 +++++++++++++++
 tb/tb_tile_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
`default_nettype none
// ==== acc_pkg : shared tile-sequencer states and default geometry ==== rev 1.0
package acc_pkg;

  localparam int c_DEF_WIDTH       = 64;
  localparam int c_DEF_LANES       = 4;
  localparam int c_DEF_ARRAY_TIMES = 16;
  localparam int c_DEF_ADDR_W      = 12;
  localparam int c_DEF_TILE_W      = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LD_IFMAP  = 3'd1,
    S_LD_WEIGHT = 3'd2,
    S_LD_BIAS   = 3'd3,
    S_ARRAY     = 3'd4,
    S_PPU       = 3'd5,
    S_NEXT      = 3'd6,
    S_DONE      = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stall_addr_counter.sv
`default_nettype none
// ==== stall_addr_counter : clearable/loadable up-counter with terminal flag ==== rev 1.0
module stall_addr_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] r_count;

  // clear beats load beats increment; holding en low is the stall
  always_ff @(posedge clk) begin
    if (rst || clear) r_count <= '0;
    else if (load)    r_count <= load_val;
    else if (en)      r_count <= r_count + W'(1);
  end

  assign count = r_count;
  assign tc    = (r_count == term);

endmodule
`default_nettype wire

// File: rtl/tile_sequencer.sv
`default_nettype none
// ==== tile_sequencer : per-tile GLB load / array / PPU job sequencer ==== rev 1.0
module tile_sequencer
  import acc_pkg::*;
#(
  parameter int WIDTH       = c_DEF_WIDTH,
  parameter int LANES       = c_DEF_LANES,
  parameter int ARRAY_TIMES = c_DEF_ARRAY_TIMES,
  parameter int ADDR_W      = c_DEF_ADDR_W,
  parameter int TILE_W      = c_DEF_TILE_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [TILE_W-1:0]              num_tiles,
  input  logic                           reuse_weight,
  input  logic                           abort,
  input  logic                           dram_valid,
  input  logic                           valid_array,
  output logic                           busy,
  output logic                           done,
  output logic                           ifmap_wen,
  output logic                           weight_wen,
  output logic                           bias_wen,
  output logic                           glb_ren,
  output logic                           ofmap_ren,
  output logic                           array_en,
  output logic                           ppu_en,
  output logic [ADDR_W-1:0]              glb_addr,
  output logic [TILE_W-1:0]              tile_idx,
  output logic [$clog2(ARRAY_TIMES)-1:0] pass_idx
);

  localparam int PASS_W = $clog2(ARRAY_TIMES);
  localparam logic [ADDR_W-1:0] c_IFMAP_LAST  = ADDR_W'(WIDTH / LANES - 1);
  localparam logic [ADDR_W-1:0] c_WEIGHT_LAST = ADDR_W'(WIDTH * WIDTH / LANES - 1);
  localparam logic [ADDR_W-1:0] c_VEC_LAST    = ADDR_W'(WIDTH - 1);
  localparam logic [PASS_W-1:0] c_PASS_LAST   = PASS_W'(ARRAY_TIMES - 1);

  generate
    if (WIDTH % LANES != 0) begin : g_chk_lanes
      $error("tile_sequencer: LANES must divide WIDTH");
    end
    if ((WIDTH * WIDTH / LANES) > (2 ** ADDR_W) || WIDTH > (2 ** ADDR_W)) begin : g_chk_addr
      $error("tile_sequencer: weight word count does not fit ADDR_W");
    end
    if (ARRAY_TIMES < 2) begin : g_chk_passes
      $error("tile_sequencer: ARRAY_TIMES must be at least 2");
    end
  endgenerate

  state_t              r_state, w_next;
  logic [TILE_W-1:0]   r_tile, r_num_tiles;
  logic                r_reuse, r_done, r_ppu_en;
  logic [PASS_W-1:0]   r_pass;
  logic [ADDR_W-1:0]   w_addr, w_term;
  logic                w_tc, w_cnt_en, w_cnt_clear, w_last_tile, w_start_ok, w_loading;

  // a job of zero tiles runs as a single tile
  assign w_last_tile = (r_tile == ((r_num_tiles == '0) ? '0 : r_num_tiles - TILE_W'(1)));
  assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_loading   = (r_state == S_LD_IFMAP) || (r_state == S_LD_WEIGHT) || (r_state == S_LD_BIAS);

  always_comb begin
    w_next = r_state;
    w_term = '0;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_LD_IFMAP;
      S_LD_IFMAP: begin
        w_term = c_IFMAP_LAST;
        if (dram_valid && w_tc) w_next = (r_reuse && r_tile != '0) ? S_LD_BIAS : S_LD_WEIGHT;
      end
      S_LD_WEIGHT: begin
        w_term = c_WEIGHT_LAST;
        if (dram_valid && w_tc) w_next = S_LD_BIAS;
      end
      S_LD_BIAS: begin
        w_term = c_VEC_LAST;
        if (dram_valid && w_tc) w_next = S_ARRAY;
      end
      S_ARRAY: if (valid_array && r_pass == c_PASS_LAST) w_next = S_PPU;
      S_PPU: begin
        w_term = c_VEC_LAST;
        if (w_tc) w_next = S_NEXT;
      end
      S_NEXT:  w_next = w_last_tile ? S_DONE : S_LD_IFMAP;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  assign w_cnt_clear = abort || (w_next != r_state);
  assign w_cnt_en    = (w_loading && dram_valid) || (r_state == S_PPU);

  stall_addr_counter #(.W(ADDR_W)) u_addr_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_cnt_clear),
    .load     (1'b0),
    .load_val ('0),
    .en       (w_cnt_en),
    .term     (w_term),
    .count    (w_addr),
    .tc       (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tile      <= '0;
      r_num_tiles <= '0;
      r_reuse     <= 1'b0;
      r_pass      <= '0;
      r_done      <= 1'b0;
      r_ppu_en    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_done   <= (w_next == S_DONE) && (r_state != S_DONE);
      r_ppu_en <= (r_state == S_PPU) && !abort;
      if (abort) begin
        r_tile      <= '0;
        r_num_tiles <= '0;
        r_reuse     <= 1'b0;
        r_pass      <= '0;
      end else begin
        if (w_start_ok) begin
          r_tile      <= '0;
          r_num_tiles <= num_tiles;
          r_reuse     <= reuse_weight;
          r_pass      <= '0;
        end
        if (r_state == S_NEXT && !w_last_tile) r_tile <= r_tile + TILE_W'(1);
        if (r_state == S_ARRAY && valid_array)
          r_pass <= (r_pass == c_PASS_LAST) ? '0 : r_pass + PASS_W'(1);
      end
    end
  end

  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done       = r_done;
  assign ifmap_wen  = (r_state == S_LD_IFMAP)  && dram_valid;
  assign weight_wen = (r_state == S_LD_WEIGHT) && dram_valid;
  assign bias_wen   = (r_state == S_LD_BIAS)   && dram_valid;
  assign glb_ren    = (r_state == S_ARRAY);
  assign array_en   = (r_state == S_ARRAY);
  assign ofmap_ren  = (r_state == S_PPU);
  assign ppu_en     = r_ppu_en;
  assign glb_addr   = w_addr;
  assign tile_idx   = r_tile;
  assign pass_idx   = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_tile_sequencer.sv
`default_nettype none
// ==== tb_tile_sequencer : directed self-checking bench for tile_sequencer ==== rev 1.0
module tb_tile_sequencer;
  import acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, reuse_weight = 1'b0, abort = 1'b0;
  logic       dram_valid = 1'b1, valid_array = 1'b0;
  logic [7:0] num_tiles = 8'd0;
  logic       busy, done, ifmap_wen, weight_wen, bias_wen, glb_ren, ofmap_ren, array_en, ppu_en;
  logic [11:0] glb_addr;
  logic [7:0]  tile_idx;
  logic [3:0]  pass_idx;

  tile_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .reuse_weight(reuse_weight),
    .abort(abort), .dram_valid(dram_valid), .valid_array(valid_array), .busy(busy), .done(done),
    .ifmap_wen(ifmap_wen), .weight_wen(weight_wen), .bias_wen(bias_wen), .glb_ren(glb_ren),
    .ofmap_ren(ofmap_ren), .array_en(array_en), .ppu_en(ppu_en), .glb_addr(glb_addr),
    .tile_idx(tile_idx), .pass_idx(pass_idx)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n_ifmap = 0, n_weight = 0, n_weight_t0 = 0, n_bias = 0, n_pass = 0;
  int n_ppu = 0, n_ofmap = 0, n_done = 0, n_addr_err = 0, n_lat_err = 0;
  int n_ifmap_tile[4] = '{0, 0, 0, 0};
  int ppu_exp = 0;
  logic prev_ofmap = 1'b0;

  int b_ifmap, b_weight, b_weight_t0, b_bias, b_pass, b_ppu, b_ofmap, b_done, b_addr_err, b_lat_err;
  int b_tile[4];

  // array model: answer every array cycle with a pulse, one cycle apart
  initial begin
    forever begin
      @(posedge clk); #1;
      valid_array = array_en && !valid_array;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_ofmap = 1'b0;
      ppu_exp    = 0;
    end else begin
      if (ifmap_wen) begin
        n_ifmap++;
        if (tile_idx < 8'd4) n_ifmap_tile[tile_idx[1:0]]++;
      end
      if (weight_wen) begin
        n_weight++;
        if (tile_idx == 8'd0) n_weight_t0++;
      end
      if (bias_wen) n_bias++;
      if (valid_array && array_en) n_pass++;
      if (ppu_en) n_ppu++;
      if (done) n_done++;
      if (ofmap_ren) begin
        n_ofmap++;
        if (glb_addr !== 12'(ppu_exp)) n_addr_err++;
        ppu_exp++;
      end else ppu_exp = 0;
      if (ppu_en !== prev_ofmap) n_lat_err++;
      prev_ofmap = ofmap_ren;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic snap();
    b_ifmap = n_ifmap; b_weight = n_weight; b_weight_t0 = n_weight_t0; b_bias = n_bias;
    b_pass = n_pass; b_ppu = n_ppu; b_ofmap = n_ofmap; b_done = n_done;
    b_addr_err = n_addr_err; b_lat_err = n_lat_err;
    for (int i = 0; i < 4; i++) b_tile[i] = n_ifmap_tile[i];
  endtask

  task automatic do_start(input logic [7:0] n, input logic reuse);
    num_tiles = n; reuse_weight = reuse; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // 0: done, 1: pass_idx==7 in ARRAY, 2: ofmap_ren, 3: weight_wen
  task automatic wait_for(input string tag, input int which, input int max_cycles);
    bit hit = 1'b0;
    for (int c = 0; c < max_cycles && !hit; c++) begin
      case (which)
        0: hit = done;
        1: hit = array_en && pass_idx == 4'd7;
        2: hit = ofmap_ren;
        default: hit = weight_wen;
      endcase
      if (!hit) tick();
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_strobes"}, 32'({busy, done, ifmap_wen, weight_wen, bias_wen, glb_ren,
                                   ofmap_ren, array_en, ppu_en}), 32'd0);
    check({tag, "_addr"}, 32'(glb_addr), 32'd0);
    check({tag, "_tile"}, 32'(tile_idx), 32'd0);
    check({tag, "_pass"}, 32'(pass_idx), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("post_reset");

    // single tile, dram_valid constant
    snap();
    do_start(8'd1, 1'b0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_wen", 32'(ifmap_wen), 32'd1);
    wait_for("t1_done_seen", 0, 6000);
    check("t1_done_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("t1_ifmap", 32'(n_ifmap - b_ifmap), 32'd16);
    check("t1_weight", 32'(n_weight - b_weight), 32'd1024);
    check("t1_bias", 32'(n_bias - b_bias), 32'd64);
    check("t1_pass", 32'(n_pass - b_pass), 32'd16);
    check("t1_ofmap", 32'(n_ofmap - b_ofmap), 32'd64);
    check("t1_ppu_en", 32'(n_ppu - b_ppu), 32'd64);
    check("t1_done_cnt", 32'(n_done - b_done), 32'd1);
    check("t1_ppu_addr", 32'(n_addr_err - b_addr_err), 32'd0);
    check("t1_ppu_lat", 32'(n_lat_err - b_lat_err), 32'd0);

    // dram_valid stalls in LD_IFMAP; restart from DONE
    snap();
    do_start(8'd1, 1'b0);
    dram_valid = 1'b1; #1;
    check("st0_wen", 32'(ifmap_wen), 32'd1);
    check("st0_addr", 32'(glb_addr), 32'd0);
    tick(); dram_valid = 1'b0; #1;
    check("st1_wen", 32'(ifmap_wen), 32'd0);
    check("st1_addr", 32'(glb_addr), 32'd1);
    tick(); dram_valid = 1'b1; #1;
    check("st2_wen", 32'(ifmap_wen), 32'd1);
    check("st2_addr", 32'(glb_addr), 32'd1);
    tick(); dram_valid = 1'b0; #1;
    check("st3_wen", 32'(ifmap_wen), 32'd0);
    check("st3_addr", 32'(glb_addr), 32'd2);
    tick(); dram_valid = 1'b1; #1;
    check("st4_addr", 32'(glb_addr), 32'd2);
    wait_for("st_done_seen", 0, 6000);
    repeat (3) tick();
    check("st_ifmap", 32'(n_ifmap - b_ifmap), 32'd16);
    check("st_weight", 32'(n_weight - b_weight), 32'd1024);

    // three tiles with weight reuse
    snap();
    do_start(8'd3, 1'b1);
    wait_for("mt_done_seen", 0, 9000);
    repeat (3) tick();
    check("mt_weight", 32'(n_weight - b_weight), 32'd1024);
    check("mt_weight_t0", 32'(n_weight_t0 - b_weight_t0), 32'd1024);
    check("mt_ifmap", 32'(n_ifmap - b_ifmap), 32'd48);
    check("mt_tile0", 32'(n_ifmap_tile[0] - b_tile[0]), 32'd16);
    check("mt_tile1", 32'(n_ifmap_tile[1] - b_tile[1]), 32'd16);
    check("mt_tile2", 32'(n_ifmap_tile[2] - b_tile[2]), 32'd16);
    check("mt_bias", 32'(n_bias - b_bias), 32'd192);
    check("mt_pass", 32'(n_pass - b_pass), 32'd48);
    check("mt_done_cnt", 32'(n_done - b_done), 32'd1);

    // abort at pass 7, start in the same cycle loses
    snap();
    do_start(8'd1, 1'b0);
    wait_for("ab_pass7", 1, 6000);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check_idle("abort");
    repeat (10) tick();
    check("ab_no_done", 32'(n_done - b_done), 32'd0);
    check("ab_still_idle", 32'(busy), 32'd0);
    snap();
    do_start(8'd1, 1'b0);
    check("ab_restart_tile", 32'(tile_idx), 32'd0);
    wait_for("ab_done_seen", 0, 6000);
    repeat (3) tick();
    check("ab_ifmap", 32'(n_ifmap - b_ifmap), 32'd16);
    check("ab_pass", 32'(n_pass - b_pass), 32'd16);
    check("ab_done_cnt", 32'(n_done - b_done), 32'd1);

    // num_tiles=0 is one tile; start during PPU ignored
    snap();
    do_start(8'd0, 1'b0);
    wait_for("ppu_seen", 2, 6000);
    tick();
    num_tiles = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("ppu_start_busy", 32'(ofmap_ren), 32'd1);
    wait_for("z_done_seen", 0, 6000);
    repeat (3) tick();
    check("z_ifmap", 32'(n_ifmap - b_ifmap), 32'd16);
    check("z_ppu_en", 32'(n_ppu - b_ppu), 32'd64);
    check("z_done_cnt", 32'(n_done - b_done), 32'd1);

    // reset in the middle of LD_WEIGHT
    snap();
    do_start(8'd2, 1'b0);
    wait_for("w_seen", 3, 200);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_idle("mid_rst");
    check("mid_rst_state", 32'(dut.r_state), 32'(S_IDLE));
    rst = 1'b0;
    repeat (10) tick();
    check("mid_rst_no_done", 32'(n_done - b_done), 32'd0);
    check("mid_rst_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
